program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Upstream feeder for the CPU core's instruction-memory debug write port (dbg_wr_en / dbg_addr / dbg_instr).
- Receives a byte stream over a valid/ready handshake, typically from a UART receiver:
  - a 4-byte little-endian word-count header, then
  - that many 32-bit little-endian instructions.
- Writes each instruction to consecutive imem byte addresses.
- Holds the core in reset until the load completes successfully.

Parameters:
- XLEN, 32, instruction/address width.
- BYTE_W, 8, stream byte width.
- MAX_WORDS, 1024, largest legal word count (imem depth).
- BASE_ADDR, 0, byte address of the first instruction written.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse that arms a new load; ignored while busy=1.
- rx_valid  in  1  stream byte valid.
- rx_data  in  BYTE_W  stream byte.
- rx_ready  out  1  loader accepts a byte this cycle.
- dbg_wr_en  out  1  imem write strobe (to core dbg_wr_en).
- dbg_addr  out  XLEN  imem byte address (to core dbg_addr).
- dbg_instr  out  XLEN  instruction word (to core dbg_instr).
- core_rst  out  1  reset request to core, active-high; 1 = core held in reset.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky header error.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous) values:
  - rx_ready=0, dbg_wr_en=0, dbg_addr=0, dbg_instr=0, busy=0, done=0, err=0.
  - core_rst=1.
  - state=IDLE; counters cleared.
- Byte transfer: a byte is accepted on a rising edge where rx_valid=1 and rx_ready=1.
  - rx_ready=1 only in RX_LEN and RX_WORD.
  - rx_data must be stable while rx_valid=1; the loader never drops a byte accepted with rx_ready=1.
- A 2-bit byte counter and a shift register assemble bytes little-endian: first byte accepted goes to [7:0], fourth to [31:24].
- State machine:
  - IDLE:
    - start=1 -> RX_LEN; busy<=1, core_rst<=1, err<=0, word_idx<=0, byte_cnt<=0.
  - RX_LEN: on the 4th accepted byte, latch N = assembled word.
    - N==0 or N>MAX_WORDS -> ERR.
    - Otherwise -> RX_WORD.
  - RX_WORD: on the 4th accepted byte -> WRITE.
    - dbg_instr <= assembled word.
    - dbg_addr <= BASE_ADDR + 4*word_idx (modulo 2^XLEN).
    - dbg_wr_en <= 1.
  - WRITE: exactly one cycle with dbg_wr_en=1; rx_ready=0.
    - dbg_wr_en <= 0.
    - If word_idx==N-1 -> DONE; else word_idx++ and -> RX_WORD.
  - DONE: one cycle; done=1, core_rst<=0, busy<=0 -> IDLE.
  - ERR: err=1, busy<=0, core_rst stays 1 -> IDLE (err stays set until the next start).
- Latency: dbg_wr_en is high in the cycle after the edge that accepted the 4th byte of a word. Minimum cost per word is 5 cycles (4 byte cycles + 1 WRITE cycle).
- dbg_addr and dbg_instr hold their last values when dbg_wr_en=0.
- Boundaries:
  - word_idx width is clog2(MAX_WORDS)+1 bits; N==MAX_WORDS is legal; no wrap occurs.
  - A start pulse while busy=1 has no effect.
  - Gaps in rx_valid (backpressure from the source side) only stall; there is no timeout.
  - core_rst remains 0 after success until the next start. On start it returns to 1 on the following edge, so the core is reset before any imem write.
  - rst asserted mid-load aborts at once to reset values. Words already written remain in imem; core_rst=1.
  - done and err are never both 1.

Decomposition:
- Package program_loader_pkg:
  - state enum {IDLE, RX_LEN, RX_WORD, WRITE, DONE, ERR};
  - HDR_BYTES=4 and WORD_BYTES=4 constants.
- Sub-module byte_assembler: 4-to-1 byte shift register with 2-bit counter.
  - Inputs: byte strobe, clear.
  - Outputs: assembled word, word_complete pulse.
  - Used for both header and instruction words.
- The FSM, address counter and output registers stay in program_loader.

Test Plan:
- Nominal two-word load:
  - Stimulus: start, then bytes 02 00 00 00, 13 05 A0 00, 93 05 B0 00 with rx_valid held high.
  - Required: dbg_wr_en pulses twice, first with addr 0x0 / instr 0x00A00513, second with addr 0x4 / instr 0x00B00593.
  - Then done pulses once, core_rst falls to 0 in the same cycle, and busy=0.
- Zero-length header:
  - Stimulus: start, then bytes 00 00 00 00.
  - Required: err=1, no dbg_wr_en, core_rst stays 1, rx_ready=0 afterwards.
- Oversize header:
  - Stimulus: N=MAX_WORDS+1 (01 04 00 00 for 1024).
  - Required: err=1, no write. A following start clears err.
- Byte-level backpressure:
  - Stimulus: one word with rx_valid toggling 1,0,0,1,...
  - Required: identical dbg_addr/dbg_instr to the continuous case; dbg_wr_en high for exactly one cycle.
- Reset mid-load:
  - Stimulus: rst=0 after 2 of the 4 bytes of word 1.
  - Required: all outputs at reset values immediately (asynchronous).
  - A fresh load after reset then writes word 0 to BASE_ADDR.
- Start while busy:
  - Stimulus: extra start pulse during RX_WORD.
  - Required: ignored; word_idx and addresses continue unchanged and the load completes normally.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_LEN,
    RX_WORD,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Little-endian 4-to-1 byte assembler; the completed word is presented
// combinationally in the same cycle as the fourth accepted byte.
module byte_assembler
  import program_loader_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe,
  input  logic              clear,
  input  logic [BYTE_W-1:0] data,
  output logic [XLEN-1:0]   word,
  output logic              complete
);

  logic [1:0]             cnt;
  logic [XLEN-BYTE_W-1:0] shift;

  // Only the first three bytes need storing; the fourth is merged on the fly.
  assign complete = strobe && (cnt == 2'(WORD_BYTES - 1));
  assign word     = {data, shift};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      shift <= '0;
    end else if (clear) begin
      cnt   <= '0;
      shift <= '0;
    end else if (strobe) begin
      cnt   <= cnt + 2'd1;
      shift <= {data, shift[XLEN-BYTE_W-1:BYTE_W]};
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed little-endian program into imem through the
// core debug write port, holding the core in reset until the load succeeds.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BYTE_W    = 8,
  parameter int MAX_WORDS = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              dbg_wr_en,
  output logic [XLEN-1:0]   dbg_addr,
  output logic [XLEN-1:0]   dbg_instr,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = $clog2(MAX_WORDS) + 1;

  state_t           state, state_d;
  logic [IDX_W-1:0] word_idx, word_idx_d;
  logic [IDX_W-1:0] n_words, n_words_d;
  logic             rx_ready_d, dbg_wr_en_d, core_rst_d, busy_d, done_d, err_d;
  logic [XLEN-1:0]  dbg_addr_d, dbg_instr_d;

  logic             byte_strobe;
  logic             asm_clear;
  logic [XLEN-1:0]  asm_word;
  logic             asm_complete;

  assign byte_strobe = rx_valid && rx_ready;

  byte_assembler #(
    .XLEN   (XLEN),
    .BYTE_W (BYTE_W)
  ) u_asm (
    .clk      (clk),
    .rst      (rst),
    .strobe   (byte_strobe),
    .clear    (asm_clear),
    .data     (rx_data),
    .word     (asm_word),
    .complete (asm_complete)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      word_idx  <= '0;
      n_words   <= '0;
      rx_ready  <= 1'b0;
      dbg_wr_en <= 1'b0;
      dbg_addr  <= '0;
      dbg_instr <= '0;
      core_rst  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      word_idx  <= word_idx_d;
      n_words   <= n_words_d;
      rx_ready  <= rx_ready_d;
      dbg_wr_en <= dbg_wr_en_d;
      dbg_addr  <= dbg_addr_d;
      dbg_instr <= dbg_instr_d;
      core_rst  <= core_rst_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d     = state;
    word_idx_d  = word_idx;
    n_words_d   = n_words;
    dbg_wr_en_d = 1'b0;
    dbg_addr_d  = dbg_addr;
    dbg_instr_d = dbg_instr;
    core_rst_d  = core_rst;
    busy_d      = busy;
    done_d      = 1'b0;
    err_d       = err;
    asm_clear   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_d    = RX_LEN;
          busy_d     = 1'b1;
          core_rst_d = 1'b1;
          err_d      = 1'b0;
          word_idx_d = '0;
          asm_clear  = 1'b1;
        end
      end
      RX_LEN: begin
        if (asm_complete) begin
          n_words_d = IDX_W'(asm_word);
          if (asm_word == '0 || asm_word > XLEN'(MAX_WORDS)) begin
            state_d = ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = RX_WORD;
          end
        end
      end
      RX_WORD: begin
        if (asm_complete) begin
          state_d     = WRITE;
          dbg_instr_d = asm_word;
          dbg_addr_d  = XLEN'(BASE_ADDR) + (XLEN'(word_idx) << 2);
          dbg_wr_en_d = 1'b1;
        end
      end
      WRITE: begin
        // The done pulse and core release are registered here so they
        // appear together during the DONE cycle.
        if (word_idx == n_words - IDX_W'(1)) begin
          state_d    = DONE;
          done_d     = 1'b1;
          core_rst_d = 1'b0;
          busy_d     = 1'b0;
        end else begin
          word_idx_d = word_idx + IDX_W'(1);
          state_d    = RX_WORD;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rx_ready_d = (state_d == RX_LEN) || (state_d == RX_WORD);
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader with a write/done monitor.
module tb_program_loader;

  localparam int MAX_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, dbg_wr_en, core_rst, busy, done, err;
  logic [31:0] dbg_addr, dbg_instr;

  int total = 0;
  int bad   = 0;

  int          wr_count = 0;
  logic [31:0] wr_addr  [4096];
  logic [31:0] wr_instr [4096];
  int          done_count = 0;
  int          both_count = 0;
  logic        done_core_rst = 1'b1;
  logic        done_busy = 1'b1;

  program_loader #(
    .XLEN      (32),
    .BYTE_W    (8),
    .MAX_WORDS (MAX_WORDS),
    .BASE_ADDR (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .dbg_wr_en (dbg_wr_en),
    .dbg_addr  (dbg_addr),
    .dbg_instr (dbg_instr),
    .core_rst  (core_rst),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Every cycle with dbg_wr_en high is logged, so a stretched strobe shows up as an extra write.
  always @(negedge clk) begin
    if (dbg_wr_en) begin
      if (wr_count < 4096) begin
        wr_addr[wr_count]  = dbg_addr;
        wr_instr[wr_count] = dbg_instr;
      end
      wr_count++;
    end
    if (done) begin
      done_count++;
      done_core_rst = core_rst;
      done_busy     = busy;
    end
    if (done && err) both_count++;
  end

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) begin
      total++; bad++;
      $display("[TB] FAIL send_byte_timeout: rx_ready=%b required 1", rx_ready);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (rx_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_rx_ready: got %b want 0", rx_ready); end
    total++; if (dbg_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_en: got %b want 0", dbg_wr_en); end
    total++; if (dbg_addr !== 32'h0 || dbg_instr !== 32'h0) begin bad++; $display("[TB] FAIL reset_addr_instr: got %h/%h want 0/0", dbg_addr, dbg_instr); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags: busy/done/err=%b%b%b want 000", busy, done, err); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("[TB] FAIL reset_core_rst: got %b want 1", core_rst); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (rx_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_quiet: rx_ready/busy=%b%b want 00", rx_ready, busy); end
  endtask

  task automatic test_nominal();
    int wb = wr_count;
    int db = done_count;
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL nom_busy_after_start: got %b want 1", busy); end
    send_word(32'd2);
    send_word(32'h00A00513);
    send_word(32'h00B00593);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wr_count - wb !== 2) begin bad++; $display("[TB] FAIL nom_write_count: got %0d want 2", wr_count - wb); end
    total++; if (wr_addr[wb] !== 32'h0 || wr_instr[wb] !== 32'h00A00513) begin bad++; $display("[TB] FAIL nom_write0: got %h/%h want 00000000/00a00513", wr_addr[wb], wr_instr[wb]); end
    total++; if (wr_addr[wb+1] !== 32'h4 || wr_instr[wb+1] !== 32'h00B00593) begin bad++; $display("[TB] FAIL nom_write1: got %h/%h want 00000004/00b00593", wr_addr[wb+1], wr_instr[wb+1]); end
    total++; if (done_count - db !== 1) begin bad++; $display("[TB] FAIL nom_done_count: got %0d want 1", done_count - db); end
    total++; if (done_core_rst !== 1'b0 || done_busy !== 1'b0) begin bad++; $display("[TB] FAIL nom_at_done: core_rst/busy=%b%b want 00", done_core_rst, done_busy); end
    total++; if (core_rst !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin bad++; $display("[TB] FAIL nom_after: core_rst/busy/err=%b%b%b want 000", core_rst, busy, err); end
  endtask

  task automatic test_zero_len();
    int wb = wr_count;
    int db = done_count;
    pulse_start();
    total++; if (core_rst !== 1'b1) begin bad++; $display("[TB] FAIL zero_core_rst_on_start: got %b want 1", core_rst); end
    send_word(32'd0);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL zero_err: got %b want 1", err); end
    total++; if (wr_count - wb !== 0 || done_count - db !== 0) begin bad++; $display("[TB] FAIL zero_no_write: writes=%0d dones=%0d want 0/0", wr_count - wb, done_count - db); end
    total++; if (core_rst !== 1'b1 || rx_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL zero_after: core_rst/rx_ready/busy=%b%b%b want 100", core_rst, rx_ready, busy); end
  endtask

  task automatic test_oversize();
    int wb = wr_count;
    int db = done_count;
    pulse_start();
    send_word(32'(MAX_WORDS + 1));
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (err !== 1'b1 || wr_count - wb !== 0) begin bad++; $display("[TB] FAIL over_err: err=%b writes=%0d want 1/0", err, wr_count - wb); end
    pulse_start();
    total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL over_restart: err/busy=%b%b want 01", err, busy); end
    send_word(32'd1);
    send_word(32'hDEADBEEF);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wr_count - wb !== 1 || wr_addr[wb] !== 32'h0 || wr_instr[wb] !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL over_reload: writes=%0d got %h/%h want 1 00000000/deadbeef", wr_count - wb, wr_addr[wb], wr_instr[wb]); end
    total++; if (done_count - db !== 1 || err !== 1'b0) begin bad++; $display("[TB] FAIL over_reload_done: dones=%0d err=%b want 1/0", done_count - db, err); end
  endtask

  task automatic test_backpressure();
    int wb = wr_count;
    int db = done_count;
    logic [31:0] w = 32'h00A00513;
    pulse_start();
    send_word(32'd1);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    total++; if (wr_count - wb !== 1) begin bad++; $display("[TB] FAIL bp_wr_cycles: got %0d want 1", wr_count - wb); end
    total++; if (wr_addr[wb] !== 32'h0 || wr_instr[wb] !== 32'h00A00513) begin bad++; $display("[TB] FAIL bp_write: got %h/%h want 00000000/00a00513", wr_addr[wb], wr_instr[wb]); end
    total++; if (done_count - db !== 1 || core_rst !== 1'b0) begin bad++; $display("[TB] FAIL bp_done: dones=%0d core_rst=%b want 1/0", done_count - db, core_rst); end
  endtask

  task automatic test_reset_mid_load();
    int wb = wr_count;
    pulse_start();
    send_word(32'd2);
    send_word(32'h12345678);
    send_byte(8'hEF);
    send_byte(8'hBE);
    rx_valid = 1'b0;
    total++; if (wr_count - wb !== 1 || dbg_instr !== 32'h12345678) begin bad++; $display("[TB] FAIL rst_pre: writes=%0d instr=%h want 1/12345678", wr_count - wb, dbg_instr); end
    #2 rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || core_rst !== 1'b1 || rx_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_ctrl: busy/core_rst/rx_ready=%b%b%b want 010", busy, core_rst, rx_ready); end
    total++; if (dbg_instr !== 32'h0 || dbg_addr !== 32'h0 || dbg_wr_en !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_data: instr=%h addr=%h wr/done/err=%b%b%b want 0/0/000", dbg_instr, dbg_addr, dbg_wr_en, done, err); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wb = wr_count;
    pulse_start();
    send_word(32'd1);
    send_word(32'h04030201);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wr_count - wb !== 1 || wr_addr[wb] !== 32'h0 || wr_instr[wb] !== 32'h04030201) begin bad++; $display("[TB] FAIL rst_reload: writes=%0d got %h/%h want 1 00000000/04030201", wr_count - wb, wr_addr[wb], wr_instr[wb]); end
  endtask

  task automatic test_start_busy();
    int wb = wr_count;
    int db = done_count;
    pulse_start();
    send_word(32'd3);
    send_word(32'h12345678);
    send_byte(8'hEF);
    rx_valid = 1'b0;
    pulse_start();
    total++; if (busy !== 1'b1 || rx_ready !== 1'b1) begin bad++; $display("[TB] FAIL sb_still_busy: busy/rx_ready=%b%b want 11", busy, rx_ready); end
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
    send_word(32'h04030201);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wr_count - wb !== 3) begin bad++; $display("[TB] FAIL sb_write_count: got %0d want 3", wr_count - wb); end
    total++; if (wr_addr[wb] !== 32'h0 || wr_addr[wb+1] !== 32'h4 || wr_addr[wb+2] !== 32'h8) begin bad++; $display("[TB] FAIL sb_addrs: got %h %h %h want 0 4 8", wr_addr[wb], wr_addr[wb+1], wr_addr[wb+2]); end
    total++; if (wr_instr[wb] !== 32'h12345678 || wr_instr[wb+1] !== 32'hDEADBEEF || wr_instr[wb+2] !== 32'h04030201) begin bad++; $display("[TB] FAIL sb_instrs: got %h %h %h want 12345678 deadbeef 04030201", wr_instr[wb], wr_instr[wb+1], wr_instr[wb+2]); end
    total++; if (done_count - db !== 1) begin bad++; $display("[TB] FAIL sb_done: got %0d want 1", done_count - db); end
  endtask

  task automatic test_max_words();
    int wb = wr_count;
    int db = done_count;
    pulse_start();
    send_word(32'(MAX_WORDS));
    for (int i = 0; i < MAX_WORDS; i++) send_word(32'(i) ^ 32'hA5000000);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wr_count - wb !== MAX_WORDS) begin bad++; $display("[TB] FAIL max_write_count: got %0d want %0d", wr_count - wb, MAX_WORDS); end
    total++; if (wr_addr[wb+512] !== 32'h800 || wr_instr[wb+512] !== 32'hA5000200) begin bad++; $display("[TB] FAIL max_mid: got %h/%h want 00000800/a5000200", wr_addr[wb+512], wr_instr[wb+512]); end
    total++; if (wr_addr[wb+MAX_WORDS-1] !== 32'hFFC || wr_instr[wb+MAX_WORDS-1] !== 32'hA50003FF) begin bad++; $display("[TB] FAIL max_last: got %h/%h want 00000ffc/a50003ff", wr_addr[wb+MAX_WORDS-1], wr_instr[wb+MAX_WORDS-1]); end
    total++; if (done_count - db !== 1 || err !== 1'b0 || core_rst !== 1'b0) begin bad++; $display("[TB] FAIL max_done: dones=%0d err=%b core_rst=%b want 1/0/0", done_count - db, err, core_rst); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_nominal();
    test_zero_len();
    test_oversize();
    test_backpressure();
    test_reset_mid_load();
    test_start_busy();
    test_max_words();
    total++; if (both_count !== 0) begin bad++; $display("[TB] FAIL done_err_overlap: got %0d want 0", both_count); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
